stack_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one push-down stack between two requesters. Each requester issues push/pop commands through a req/ack handshake. The block serialises the commands, drives the stack's enable, direction and write-data inputs, and captures pop data. It keeps its own occupancy count, so pushes to a full stack and pops from an empty stack are rejected with an error instead of reaching the stack.

---
 rtl/stack_arbiter.sv | 142 ++++++++++++++
 tb/tb_stack_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// stack_arbiter : two-requester arbiter/sequencer for one shared push-down stack
// Optional: STACK_ARBITER_FIXED_PRIO_EN selects fixed priority (requester 0 wins)
// Revision: 1.0
// ============================================================================
module stack_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 op0,
  input  logic                 op1,
  input  logic [DATAWIDTH-1:0] wdata0,
  input  logic [DATAWIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 err0,
  output logic                 err1,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 stk_en,
  output logic                 stk_pushpop,
  output logic [DATAWIDTH-1:0] stk_wdata,
  input  logic [DATAWIDTH-1:0] stk_rdata,
  output logic [ADDRWIDTH-1:0] level,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [ADDRWIDTH-1:0] c_full_level = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_win;
  logic                 r_op;
  logic                 r_err;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [DATAWIDTH-1:0] r_rdata;
  logic [ADDRWIDTH-1:0] r_level;
  logic                 w_grant;
  logic                 w_any_req;
  logic                 w_accept;

  assign w_any_req = req0 | req1;
  assign full      = (r_level == c_full_level);
  assign empty     = (r_level == '0);
  assign w_accept  = r_op ? !empty : !full;

`ifdef STACK_ARBITER_FIXED_PRIO_EN
  assign w_grant = !req0;
`else
  logic r_rr;

  // r_rr names the requester that wins the next simultaneous request
  assign w_grant = (req0 && req1) ? r_rr : req1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rr <= 1'b0;
    end else if (r_state == RESP) begin
      r_rr <= !r_win;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    stk_en      = 1'b0;
    case (r_state)
      IDLE:  if (w_any_req) w_state_nxt = ISSUE;
      ISSUE: begin
        w_state_nxt = RESP;
        // a reset landing in ISSUE must not let the command reach the stack
        stk_en      = w_accept && !Rst;
      end
      RESP: begin
        w_state_nxt = IDLE;
        ack0        = !r_win && !Rst;
        ack1        = r_win && !Rst;
        err0        = !r_win && !Rst && r_err;
        err1        = r_win && !Rst && r_err;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_win   <= 1'b0;
      r_op    <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_win   <= w_grant;
            r_op    <= w_grant ? op1 : op0;
            r_wdata <= w_grant ? wdata1 : wdata0;
          end
        end
        ISSUE: begin
          r_err <= !w_accept;
          if (w_accept) begin
            if (r_op) begin
              r_rdata <= stk_rdata;
              r_level <= r_level - 1'b1;
            end else begin
              r_level <= r_level + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // the latched command doubles as the stack drive, so it holds between commands
  assign stk_pushpop = r_op;
  assign stk_wdata   = r_wdata;
  assign rdata       = r_rdata;
  assign level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// tb_stack_arbiter : randomized scoreboard bench with a queue-based stack model
// Revision: 1.0
// ============================================================================
module tb_stack_arbiter;

  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int CAP = (1 << AW) - 1;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          req0, req1, op0, op1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata;
  logic          stk_en, stk_pushpop;
  logic [DW-1:0] stk_wdata, stk_rdata;
  logic [AW-1:0] level;
  logic          full, empty;

  always #5 Clk = ~Clk;

  stack_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .stk_en(stk_en), .stk_pushpop(stk_pushpop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .level(level), .full(full), .empty(empty)
  );

  // external stack: pointer to next free slot, asynchronous read of the top entry
  logic [DW-1:0] smem [0:(1<<AW)-1];
  logic [AW-1:0] sp;
  assign stk_rdata = smem[sp - 1'b1];

  always @(posedge Clk) begin
    if (Rst) sp <= '0;
    else if (stk_en) begin
      if (!stk_pushpop) begin
        smem[sp] <= stk_wdata;
        sp       <= sp + 1'b1;
      end else begin
        sp <= sp - 1'b1;
      end
    end
  end

  typedef struct {
    bit            id;
    bit            op;
    bit            err;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
    int            lvl;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] model_rdata;
  bit            model_rr;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a bounded LIFO plus "serve the one not served last"
  task automatic model_cmd(input bit id, input bit op, input logic [DW-1:0] d);
    exp_t e;
    e.id = id; e.op = op; e.data = d;
    if (!op) begin
      e.err = (mq.size() >= CAP);
      if (!e.err) mq.push_back(d);
    end else begin
      e.err = (mq.size() == 0);
      if (!e.err) model_rdata = mq.pop_back();
    end
    e.rdata  = model_rdata;
    e.lvl    = mq.size();
    model_rr = !id;
    sb.push_back(e);
  endtask

  task automatic round(input bit v0, input bit o0, input logic [DW-1:0] d0,
                       input bit v1, input bit o1, input logic [DW-1:0] d1);
    bit first;
    bit p0, p1;
    int budget;
`ifdef STACK_ARBITER_FIXED_PRIO_EN
    first = (v0 && v1) ? 1'b0 : v1;
`else
    first = (v0 && v1) ? model_rr : v1;
`endif
    if (!first) begin
      if (v0) model_cmd(0, o0, d0);
      if (v1) model_cmd(1, o1, d1);
    end else begin
      if (v1) model_cmd(1, o1, d1);
      if (v0) model_cmd(0, o0, d0);
    end
    req0 = v0; op0 = o0; wdata0 = d0;
    req1 = v1; op1 = o1; wdata1 = d1;
    p0 = v0; p1 = v1; budget = 40;
    while ((p0 || p1) && budget > 0) begin
      @(negedge Clk);
      if (ack0) begin p0 = 0; req0 = 0; end
      if (ack1) begin p1 = 0; req1 = 0; end
      budget--;
    end
    if (p0 || p1) begin
      checks++; errors++;
      $display("FAIL round_timeout: pending req0=%0d req1=%0d", p0, p1);
      req0 = 0; req1 = 0;
    end
  endtask

  // monitor: pops the scoreboard on every ack, independent of the driver
  int            en_cnt = 0;
  logic          last_pp;
  logic [DW-1:0] last_wd;
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      en_cnt = 0;
    end else begin
      if (ack0 && ack1) begin
        checks++; errors++;
        $display("FAIL dual_ack: both acks high at %0t", $time);
      end else if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack0=%0d ack1=%0d at %0t", ack0, ack1, $time);
        end else begin
          e = sb.pop_front();
          chk("ack_id", {31'd0, ack1}, {31'd0, e.id});
          chk("err", {31'd0, e.id ? err1 : err0}, {31'd0, e.err});
          chk("level", {22'd0, level}, e.lvl);
          chk("full", {31'd0, full}, {31'd0, e.lvl == CAP});
          chk("empty", {31'd0, empty}, {31'd0, e.lvl == 0});
          chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
          chk("stk_en_pulses", en_cnt, e.err ? 0 : 1);
          if (!e.err) begin
            chk("stk_pushpop", {31'd0, last_pp}, {31'd0, e.op});
            if (!e.op) chk("stk_wdata", {24'd0, last_wd}, {24'd0, e.data});
          end
        end
        en_cnt = 0;
      end
      if (stk_en) begin
        en_cnt++;
        last_pp = stk_pushpop;
        last_wd = stk_wdata;
      end
    end
  end

  initial begin
    Rst = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = '0; wdata1 = '0;
    model_rdata = '0; model_rr = 0;
    repeat (3) @(negedge Clk);
    Rst = 0;
    #1;
    chk("rst_ack", {30'd0, ack1, ack0}, 0);
    chk("rst_err", {30'd0, err1, err0}, 0);
    chk("rst_stk_en", {31'd0, stk_en}, 0);
    chk("rst_pushpop", {31'd0, stk_pushpop}, 0);
    chk("rst_wdata", {24'd0, stk_wdata}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_level", {22'd0, level}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);

    // latency: stk_en one cycle after the sampling edge, ack the cycle after
    model_cmd(0, 0, 8'hA5);
    req0 = 1; op0 = 0; wdata0 = 8'hA5;
    @(negedge Clk);
    chk("lat_stk_en", {31'd0, stk_en}, 1);
    chk("lat_pushpop", {31'd0, stk_pushpop}, 0);
    chk("lat_wdata", {24'd0, stk_wdata}, 8'hA5);
    chk("lat_no_ack_yet", {31'd0, ack0}, 0);
    @(negedge Clk);
    chk("lat_ack0", {31'd0, ack0}, 1);
    chk("lat_err0", {31'd0, err0}, 0);
    chk("lat_level", {22'd0, level}, 1);
    req0 = 0;
    round(1, 1, 8'h00, 0, 0, 8'h00);

    round(0, 0, 8'h00, 1, 0, 8'h11);
    round(0, 0, 8'h00, 1, 0, 8'h22);
    round(1, 1, 8'h00, 0, 0, 8'h00);
    round(1, 1, 8'h00, 0, 0, 8'h00);
    chk("lifo_empty", {31'd0, empty}, 1);

    round(0, 0, 8'h00, 1, 1, 8'h00);
    round(1, 1, 8'h00, 0, 0, 8'h00);

    for (int i = 0; i < 4; i++)
      round(1, 0, DW'($urandom), 1, 0, DW'($urandom));

    for (int i = 0; i < 200; i++) begin
      bit a, b;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if (!a && !b) a = 1;
      round(a, 1'($urandom_range(0, 1)), DW'($urandom),
            b, 1'($urandom_range(0, 1)), DW'($urandom));
    end

    while (mq.size() < CAP) begin
      if ($urandom_range(0, 1) == 0) round(1, 0, DW'($urandom), 0, 0, 8'h00);
      else                           round(0, 0, 8'h00, 1, 0, DW'($urandom));
    end
    round(1, 0, 8'h5A, 0, 0, 8'h00);
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_level", {22'd0, level}, CAP);
    for (int i = 0; i < 20; i++)
      round(1'(i % 2), 1, 8'h00, 1'((i + 1) % 2), 1, 8'h00);

    // reset while a push is in ISSUE: command dropped, no stack access
    req0 = 1; op0 = 0; wdata0 = 8'h3C;
    @(negedge Clk);
    Rst = 1;
    #1;
    chk("midrst_stk_en", {31'd0, stk_en}, 0);
    @(negedge Clk);
    Rst = 0; req0 = 0;
    mq.delete(); model_rdata = '0; model_rr = 0;
    #1;
    chk("midrst_level", {22'd0, level}, 0);
    chk("midrst_empty", {31'd0, empty}, 1);
    chk("midrst_rdata", {24'd0, rdata}, 0);
    repeat (4) @(negedge Clk);
    round(1, 0, 8'hC3, 0, 0, 8'h00);
    round(0, 0, 8'h00, 1, 1, 8'h00);

    repeat (4) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
